// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard controller: operand-select
// encodings and the default register-address width.
package fwd_pkg;

  // Operand mux select encodings (value 3 is never produced)
  localparam logic [1:0] SEL_RF  = 2'd0;  // register file
  localparam logic [1:0] SEL_EXM = 2'd1;  // EX/MEM result
  localparam logic [1:0] SEL_MWB = 2'd2;  // MEM/WB result

  // Default register-address width: 16 architectural registers, r0 is zero
  localparam int DEF_REG_AW = 4;

endpackage

// File: rtl/fwd_cmp.sv
// Single-operand forwarding comparator. Checks one source register against
// the EX and MEM destination slots and returns the operand mux select.
// The newest producer (EX) wins over the older one (MEM); r0 never forwards.
module fwd_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  output logic [1:0]        sel
);

  // Priority match: EX slot first, then MEM slot, else register file
  always_comb begin
    sel = SEL_RF;
    if (use_src && (src != '0)) begin
      if (ex_we && (ex_rd == src)) begin
        sel = SEL_EXM;
      end else if (mem_we && (mem_rd == src)) begin
        sel = SEL_MWB;
      end
    end
  end

endmodule

// File: rtl/fwd_sel_unit.sv
// Pipeline forwarding and load-use hazard controller.
// Tracks the destination registers of the instructions in EX and MEM,
// registers the ALU operand A/B selects so they line up with the
// instruction in EX, and raises a combinational load-use stall request.
// Optional event counters are built only when FWD_CNT_EN is defined;
// otherwise fwd_cnt/stall_cnt are tied to zero.
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_ld,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall_req,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Stage slots
  logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
  logic              ex_we_q,  ex_we_d;
  logic              ex_ld_q,  ex_ld_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;

  // Registered selects
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  logic [1:0] cmp_a, cmp_b;
  logic       bubble;

  fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .src     (id_rs),
    .use_src (1'b1),
    .ex_rd   (ex_rd_q),
    .ex_we   (ex_we_q),
    .mem_rd  (mem_rd_q),
    .mem_we  (mem_we_q),
    .sel     (cmp_a)
  );

  fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .ex_rd   (ex_rd_q),
    .ex_we   (ex_we_q),
    .mem_rd  (mem_rd_q),
    .mem_we  (mem_we_q),
    .sel     (cmp_b)
  );

  // Load-use hazard: a load in EX produces a register the ID instruction reads
  always_comb begin
    stall_req = ex_ld_q && ex_we_q && (ex_rd_q != '0) &&
                ((ex_rd_q == id_rs) || (id_use_rt && (ex_rd_q == id_rt)));
  end

  // Next-state: stall and flush both collapse into a single bubble in EX;
  // MEM always advances so the load reaches MEM/WB and can be forwarded
  always_comb begin
    bubble   = stall_req || flush;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    if (bubble) begin
      ex_rd_d = '0;
      ex_we_d = 1'b0;
      ex_ld_d = 1'b0;
      sel_a_d = SEL_RF;
      sel_b_d = SEL_RF;
    end else begin
      ex_rd_d = id_rd;
      ex_we_d = id_we;
      ex_ld_d = id_ld;
      sel_a_d = cmp_a;
      sel_b_d = cmp_b;
    end
  end

  // Slot and select registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

`ifdef FWD_CNT_EN
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counters: one forward event per cycle, not per operand
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (((sel_a_d != SEL_RF) || (sel_b_d != SEL_RF)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
    if (stall_req && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fwd_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Self-checking bench for fwd_sel_unit: directed scenarios followed by
// randomized instruction streams compared against a behavioural model.
module tb_fwd_sel_unit;

  localparam int REG_AW  = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_use_rt = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_we = 1'b0;
  logic              id_ld = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        sel_a, sel_b;
  logic              stall_req;
  logic [CNT_W-1:0]  fwd_cnt, stall_cnt;

  fwd_sel_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rt (id_use_rt),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_ld     (id_ld),
    .flush     (flush),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .stall_req (stall_req),
    .fwd_cnt   (fwd_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions ahead of ID, index = age (0 newest)
  typedef struct {
    int rd;
    bit we;
    bit ld;
  } instr_t;

  instr_t inflight [2];
  int     m_sel_a, m_sel_b, m_fwd, m_stall;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) inflight[i] = '{rd: 0, we: 0, ld: 0};
    m_sel_a = 0; m_sel_b = 0; m_fwd = 0; m_stall = 0;
  endfunction

  // Select = 1 + age of the youngest in-flight writer of src; r0 never forwards
  function automatic int model_sel(input int src);
    if (src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (inflight[age].we && inflight[age].rd == src) return age + 1;
    return 0;
  endfunction

  function automatic bit model_hazard(input int rs, input int rt, input bit use_rt);
    instr_t p;
    p = inflight[0];
    return p.ld && p.we && p.rd != 0 && (p.rd == rs || (use_rt && p.rd == rt));
  endfunction

  task automatic check_outputs();
    check("sel_a", int'(sel_a), m_sel_a);
    check("sel_b", int'(sel_b), m_sel_b);
`ifdef FWD_CNT_EN
    check("fwd_cnt", int'(fwd_cnt), m_fwd);
    check("stall_cnt", int'(stall_cnt), m_stall);
`else
    check("fwd_cnt_tied", int'(fwd_cnt), 0);
    check("stall_cnt_tied", int'(stall_cnt), 0);
`endif
  endtask

  // One ID cycle: present instruction, check stall, clock, check selects
  task automatic step(input int rs, input int rt, input bit use_rt,
                      input int rd, input bit we, input bit ld, input bit fl);
    bit haz;
    int na, nb;
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_use_rt = use_rt;
    id_rd = REG_AW'(rd); id_we = we; id_ld = ld; flush = fl;
    #1;
    haz = model_hazard(rs, rt, use_rt);
    check("stall_req", int'(stall_req), int'(haz));
    na = model_sel(rs);
    nb = use_rt ? model_sel(rt) : 0;
    if (haz || fl) begin na = 0; nb = 0; end
    @(posedge clk);
    if ((na != 0 || nb != 0) && m_fwd < CNT_MAX) m_fwd++;
    if (haz && m_stall < CNT_MAX) m_stall++;
    inflight[1] = inflight[0];
    if (haz || fl) inflight[0] = '{rd: 0, we: 0, ld: 0};
    else           inflight[0] = '{rd: rd, we: we, ld: ld};
    m_sel_a = na; m_sel_b = nb;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rs = REG_AW'($urandom); id_rt = REG_AW'($urandom); id_rd = REG_AW'($urandom);
      id_use_rt = 1'($urandom); id_we = 1'($urandom); id_ld = 1'($urandom); flush = 1'b0;
      @(posedge clk); #1;
      check("rst_sel_a", int'(sel_a), 0);
      check("rst_sel_b", int'(sel_b), 0);
      check("rst_stall", int'(stall_req), 0);
    end
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset();
    // idle cycles after release keep outputs at zero
    step(1, 2, 1, 0, 0, 0, 0);
    step(3, 4, 1, 0, 0, 0, 0);
    check("idle_sel_a", int'(sel_a), 0);

    // EX forward
    step(0, 0, 0, 5, 1, 0, 0);
    step(5, 0, 0, 0, 0, 0, 0);
    check("ex_fwd_a", int'(sel_a), 1);

    // MEM forward, and EX priority over MEM
    do_reset();
    step(0, 0, 0, 5, 1, 0, 0);
    step(0, 0, 0, 7, 1, 0, 0);
    step(5, 0, 0, 0, 0, 0, 0);
    check("mem_fwd_a", int'(sel_a), 2);
    step(0, 0, 0, 5, 1, 0, 0);
    step(0, 0, 0, 5, 1, 0, 0);
    step(5, 0, 0, 0, 0, 0, 0);
    check("prio_fwd_a", int'(sel_a), 1);

    // Load-use: one-cycle stall, then MEM/WB forward
    do_reset();
    step(0, 0, 0, 3, 1, 1, 0);
    step(3, 0, 0, 8, 1, 0, 0);
    check("lu_bubble_a", int'(sel_a), 0);
    step(3, 0, 0, 8, 1, 0, 0);
    check("lu_fwd_a", int'(sel_a), 2);
    check("lu_stall_gone", int'(stall_req), 0);
`ifdef FWD_CNT_EN
    check("lu_stall_cnt", int'(stall_cnt), 1);
`endif

    // r0 never forwards; unused rt never forwards
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("r0_sel_a", int'(sel_a), 0);
    check("r0_sel_b", int'(sel_b), 0);
    step(0, 0, 0, 4, 1, 0, 0);
    step(0, 4, 0, 0, 0, 0, 0);
    check("no_use_rt_b", int'(sel_b), 0);
    step(0, 0, 0, 4, 1, 0, 0);
    step(0, 4, 1, 0, 0, 0, 0);
    check("use_rt_b", int'(sel_b), 1);

    // Flushed writer is squashed
    step(0, 0, 0, 6, 1, 0, 1);
    step(6, 0, 0, 0, 0, 0, 0);
    check("flush_sel_a", int'(sel_a), 0);

    // Async reset in the middle of a stall cycle
    do_reset();
    step(0, 0, 0, 2, 1, 0, 0);
    step(2, 0, 0, 3, 1, 1, 0);
    check("pre_rst_sel_a", int'(sel_a), 1);
    id_rs = 4'd3; id_rt = 4'd0; id_use_rt = 1'b0; id_rd = 4'd0; id_we = 1'b0; id_ld = 1'b0;
    #1;
    check("pre_rst_stall", int'(stall_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_stall", int'(stall_req), 0);
    check("async_rst_sel_a", int'(sel_a), 0);
    check("async_rst_sel_b", int'(sel_b), 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_sel_unit.md
Name: fwd_sel_unit

Overview:
- Pipeline forwarding and hazard controller.
- Tracks destination registers of the two instructions ahead of the one in ID (EX and MEM stages).
- Produces registered 2-bit selects for the ALU operand A/B 3-to-1 muxes. Encoding: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- Raises a load-use stall request.
- Sits directly upstream of the operand-select muxes, between the decode stage and EX.

Parameters:
- REG_AW, 4, register-address width (16 architectural registers; r0 hardwired zero).
- CNT_W, 16, width of the optional event counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_rs  input  REG_AW  source A register of the instruction in ID.
- id_rt  input  REG_AW  source B register of the instruction in ID.
- id_use_rt  input  1  instruction in ID reads id_rt.
- id_rd  input  REG_AW  destination register of the instruction in ID.
- id_we  input  1  instruction in ID writes id_rd.
- id_ld  input  1  instruction in ID is a load.
- flush  input  1  squash the instruction leaving ID (branch taken).
- sel_a  output  2  operand A mux select, aligned with the instruction in EX.
- sel_b  output  2  operand B mux select, aligned with the instruction in EX.
- stall_req  output  1  load-use hazard; ID/IF must hold.
- fwd_cnt  output  CNT_W  forwarding events (only with FWD_CNT_EN).
- stall_cnt  output  CNT_W  stall cycles (only with FWD_CNT_EN).

Behaviour:
- Clock, reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all internal stage registers clear. ex_we, ex_ld, mem_we = 0; ex_rd, mem_rd = 0. sel_a, sel_b = 0; stall_req = 0; counters = 0.
- State: two stage slots.
  - EX slot: ex_rd, ex_we, ex_ld.
  - MEM slot: mem_rd, mem_we.
- Normal advance (stall_req=0, flush=0), each edge:
  - EX slot <= {id_rd, id_we, id_ld}.
  - MEM slot <= {ex_rd, ex_we}.
- Bubble (stall_req=1 or flush=1): EX slot <= {0,0,0}. MEM slot still advances from EX.
- Next sel_a, computed from pre-edge slot contents:
  - 1 if ex_we and ex_rd==id_rs and id_rs!=0.
  - else 2 if mem_we and mem_rd==id_rs and id_rs!=0.
  - else 0.
  - EX match has priority over MEM (newest value wins).
- Next sel_b: same rule using id_rt, gated by id_use_rt; 0 when id_use_rt=0.
- sel_a/sel_b are registered: values computed in cycle N appear in cycle N+1, when the instruction is in EX. Latency 1 cycle.
- On a bubble edge, sel_a and sel_b load 0.
- Value 3 is never driven on sel_a or sel_b.
- stall_req is combinational. It is asserted when all of the following hold:
  - ex_ld=1, ex_we=1, ex_rd!=0;
  - ex_rd==id_rs, or (id_use_rt=1 and ex_rd==id_rt).
- A load-use stall always lasts exactly 1 cycle. The bubble clears ex_ld, so stall_req falls next cycle. The following edge then forwards with sel=2.
- flush and stall_req together: treated as a single bubble, identical effect.
- Writes to r0: never forwarded. A match on register 0 yields sel 0 and no stall.
- rst asserted mid-operation: slots and outputs clear immediately; no pending stall survives.

Optional Feature:
- Macro: FWD_CNT_EN.
- Defined:
  - fwd_cnt increments on each edge where the next sel_a!=0 or next sel_b!=0; +1 per cycle, not per operand.
  - stall_cnt increments on each cycle stall_req=1.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: fwd_cnt and stall_cnt are tied to 0; no counter flops are synthesized. Port list is unchanged.

Decomposition:
- Package fwd_pkg holds:
  - SEL_RF=2'd0, SEL_EXM=2'd1, SEL_MWB=2'd2;
  - default REG_AW.
- Sub-module fwd_cmp (combinational): compares one source register against the EX and MEM slots and returns the 2-bit select. Instantiated twice, for A and B.

Test Plan:
- Reset: hold rst with random ID inputs -> sel_a=sel_b=0, stall_req=0. Release rst -> outputs stay 0 until the first matching instruction.
- EX forward: issue id_rd=5/id_we=1, then id_rs=5 -> on the cycle after the second issue, sel_a=1.
- MEM forward with priority:
  - issue rd=5, then rd=7, then rs=5 -> sel_a=2.
  - issue rd=5, then rd=5, then rs=5 -> sel_a=1.
- Load-use: issue load rd=3 (id_ld=1), then rs=3 -> stall_req=1 for exactly 1 cycle, then sel_a=2. With FWD_CNT_EN, stall_cnt=1.
- r0 and id_use_rt:
  - issue rd=0/we=1, then rs=0 -> sel_a=0.
  - issue rd=4, then rt=4 with id_use_rt=0 -> sel_b=0.
- Flush and async reset:
  - issue rd=6 with flush=1, then rs=6 -> sel_a=0.
  - assert rst between clock edges during a stall -> stall_req and sels drop to 0 immediately.
